// File: rtl/phase_unwrap_gray_if.sv
// Pixel stream bundle for the gray-code phase unwrapper.
// master drives gray words and wrapped phase, slave returns absolute phase.
interface phase_unwrap_gray_if #(
  parameter int GRAY_BITS    = 4,
  parameter int ARCTAN_WIDTH = 32,
  parameter int OUT_WIDTH    = 32
);
  logic [GRAY_BITS:0]             gray_code;
  logic                           gray_valid;
  logic                           wrapped_phase_valid;
  logic signed [ARCTAN_WIDTH-1:0] arctan_in;
  logic                           unwrapped_valid;
  logic signed [OUT_WIDTH-1:0]    unwrapped_phase;
  logic                           fifo_overflow;
  logic                           fifo_underflow;

  modport master (
    output gray_code, gray_valid,
    output wrapped_phase_valid, arctan_in,
    input  unwrapped_valid, unwrapped_phase,
    input  fifo_overflow, fifo_underflow
  );

  modport slave (
    input  gray_code, gray_valid,
    input  wrapped_phase_valid, arctan_in,
    output unwrapped_valid, unwrapped_phase,
    output fifo_overflow, fifo_underflow
  );
endinterface

// File: rtl/phase_unwrap_gray.sv
// Gray-code fringe phase unwrapper: FIFO of gray words, PHI = phi0 + k*2pi.
// Define PHASE_UNWRAP_CGC_EN for complementary-gray correction (+1 stage).
module phase_unwrap_gray #(
  parameter int ARCTAN_WIDTH = 32,
  parameter int PHASE_FRAC   = 16,
  parameter int GRAY_BITS    = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int OUT_WIDTH    = 32
) (
  input logic clk,
  input logic rst,
  phase_unwrap_gray_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int KW    = GRAY_BITS + 3;

  localparam real    SCALE    = real'(longint'(1) << PHASE_FRAC);
  localparam longint TWO_PI_L = longint'(6.283185307179586 * SCALE);

  localparam logic signed [ARCTAN_WIDTH-1:0] TWO_PI_A =
    ARCTAN_WIDTH'(TWO_PI_L);
  localparam logic signed [OUT_WIDTH-1:0] TWO_PI_O =
    OUT_WIDTH'(TWO_PI_L);

  function automatic logic [GRAY_BITS-1:0] g2b_k(
    input logic [GRAY_BITS-1:0] g
  );
    logic [GRAY_BITS-1:0] b;
    b[GRAY_BITS-1] = g[GRAY_BITS-1];
    for (int i = GRAY_BITS - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [GRAY_BITS:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push, pop, empty, full;
  logic                 do_push, do_pop;
  logic                 ovf_q, unf_q;
  logic [GRAY_BITS:0]   pop_code;

  assign push     = bus.gray_valid;
  assign pop      = bus.wrapped_phase_valid;
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | pop);
  assign pop_code = empty ? '0 : mem[rd_ptr];

  // FIFO pointers, occupancy and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
      if (push && full && !pop) ovf_q <= 1'b1;
      if (pop && empty)         unf_q <= 1'b1;
    end
  end

  // Gray word storage; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= bus.gray_code;
  end

  logic signed [ARCTAN_WIDTH-1:0] phi0_in;
  assign phi0_in = bus.arctan_in[ARCTAN_WIDTH-1]
                 ? bus.arctan_in + TWO_PI_A
                 : bus.arctan_in;

  logic                           s1_valid;
  logic signed [ARCTAN_WIDTH-1:0] s1_phi0;
  logic [GRAY_BITS-1:0]           s1_k1;

  logic                           fin_valid;
  logic signed [ARCTAN_WIDTH-1:0] fin_phi0;
  logic signed [KW-1:0]           fin_k;

`ifdef PHASE_UNWRAP_CGC_EN
  localparam longint HALF_L  = longint'(1.5707963267948966 * SCALE);
  localparam longint THREE_L = longint'(4.71238898038469 * SCALE);
  localparam logic signed [ARCTAN_WIDTH-1:0] HALF_PI =
    ARCTAN_WIDTH'(HALF_L);
  localparam logic signed [ARCTAN_WIDTH-1:0] THREE_HALF_PI =
    ARCTAN_WIDTH'(THREE_L);

  function automatic logic [GRAY_BITS:0] g2b_c(
    input logic [GRAY_BITS:0] g
  );
    logic [GRAY_BITS:0] b;
    b[GRAY_BITS] = g[GRAY_BITS];
    for (int i = GRAY_BITS - 1; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [GRAY_BITS+1:0] k2_sum;
  logic [GRAY_BITS:0]   s1_k2;
  logic                 s2_valid;
  logic signed [ARCTAN_WIDTH-1:0] s2_phi0;
  logic signed [KW-1:0] s2_k;
  logic [KW-1:0]        k_sel;

  assign k2_sum = {1'b0, g2b_c(pop_code)} + 1'b1;

  // Stage 1: map phase, decode both gray readings
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_phi0  <= '0;
      s1_k1    <= '0;
      s1_k2    <= '0;
    end else begin
      s1_valid <= pop;
      if (pop) begin
        s1_phi0 <= phi0_in;
        s1_k1   <= g2b_k(pop_code[GRAY_BITS:1]);
        s1_k2   <= k2_sum[GRAY_BITS+1:1];
      end
    end
  end

  // Pick fringe order by quadrant of the mapped phase
  always_comb begin
    k_sel = {3'b000, s1_k1};
    unique case (1'b1)
      (s1_phi0 < HALF_PI):
        k_sel = {2'b00, s1_k2};
      (s1_phi0 >= THREE_HALF_PI):
        k_sel = {2'b00, s1_k2} - KW'(1);
      default:
        k_sel = {3'b000, s1_k1};
    endcase
  end

  // Stage 2: register corrected order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_phi0  <= '0;
      s2_k     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_phi0 <= s1_phi0;
        s2_k    <= k_sel;
      end
    end
  end

  assign fin_valid = s2_valid;
  assign fin_phi0  = s2_phi0;
  assign fin_k     = s2_k;
`else
  logic unused_cgc;
  assign unused_cgc = pop_code[0];

  // Stage 1: map phase, decode fringe order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_phi0  <= '0;
      s1_k1    <= '0;
    end else begin
      s1_valid <= pop;
      if (pop) begin
        s1_phi0 <= phi0_in;
        s1_k1   <= g2b_k(pop_code[GRAY_BITS:1]);
      end
    end
  end

  assign fin_valid = s1_valid;
  assign fin_phi0  = s1_phi0;
  assign fin_k     = {3'b000, s1_k1};
`endif

  logic signed [OUT_WIDTH-1:0] phi_ext, k_ext;
  logic                        out_valid;
  logic signed [OUT_WIDTH-1:0] out_phase;

  assign phi_ext = OUT_WIDTH'(fin_phi0);
  assign k_ext   = OUT_WIDTH'(fin_k);

  // Final stage: absolute phase, held between pixels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_phase <= '0;
    end else begin
      out_valid <= fin_valid;
      if (fin_valid)
        out_phase <= phi_ext + k_ext * TWO_PI_O;
    end
  end

  assign bus.unwrapped_valid = out_valid;
  assign bus.unwrapped_phase = out_phase;
  assign bus.fifo_overflow   = ovf_q;
  assign bus.fifo_underflow  = unf_q;

endmodule
